// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : Debounces the mode/inc/dec buttons and runs the set-time FSM that
//            edits hour/minute and loads them into the counter chain.
//            Optional inc/dec auto-repeat is built when TSET_AUTOREPEAT_EN is defined.
// Revision : 1.0
// ============================================================================
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned TIMEOUT_CYCLES    = 1500000000,
    parameter int unsigned BLINK_HALF_CYCLES = 25000000
`ifdef TSET_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY      = 50000000,
    parameter int unsigned REPEAT_PERIOD     = 10000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       load,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] btn_press;
    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic [1:0]      sync_q;
        logic            level_q;
        logic            press_q;
        logic [DB_W-1:0] cnt_q;

        // press_q rises together with the debounced level, so it lasts one cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= 2'b00;
                level_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync_q  <= {sync_q[0], btn_raw[gi]};
                press_q <= 1'b0;
                if (sync_q[1] != level_q) begin
                    if (cnt_q == DB_LAST) begin
                        level_q <= sync_q[1];
                        press_q <= sync_q[1];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign btn_press[gi] = press_q;
    end

    state_t          state_q, state_d;
    logic [4:0]      set_hour_q, set_hour_d;
    logic [5:0]      set_min_q, set_min_d;
    logic            load_q, load_d;
    logic [TO_W-1:0] idle_q, idle_d;
    logic            blink_q, blink_d;
    logic [BL_W-1:0] bcnt_q, bcnt_d;

    logic mode_evt, inc_evt, dec_evt, adj_inc, adj_dec, any_evt;
    assign mode_evt = btn_press[0];

`ifdef TSET_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    logic [RP_W-1:0] rep_cnt_q;
    logic            rep_first_q, rep_held, rep_fire;

    assign rep_held = (state_q != ST_RUN) && (g_btn[1].level_q ^ g_btn[2].level_q);
    assign rep_fire = rep_held && (rep_cnt_q == (rep_first_q ? RP_W'(REPEAT_DELAY)
                                                               : RP_W'(REPEAT_PERIOD)));

    // Counter stays at 0 until a real press arms it, so a held button never repeats on its own
    always_ff @(posedge clk) begin
        if (rst || !rep_held) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else if (btn_press[1] || btn_press[2]) begin
            rep_cnt_q   <= RP_W'(1);
            rep_first_q <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt_q   <= RP_W'(1);
            rep_first_q <= 1'b0;
        end else if (rep_cnt_q != '0) begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end

    assign inc_evt = btn_press[1] | (rep_fire & g_btn[1].level_q);
    assign dec_evt = btn_press[2] | (rep_fire & g_btn[2].level_q);
`else
    assign inc_evt = btn_press[1];
    assign dec_evt = btn_press[2];
`endif

    assign adj_inc = inc_evt & ~dec_evt;
    assign adj_dec = dec_evt & ~inc_evt;
    assign any_evt = mode_evt | inc_evt | dec_evt;

    always_comb begin
        state_d    = state_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        load_d     = 1'b0;
        idle_d     = '0;
        blink_d    = blink_q;
        bcnt_d     = bcnt_q;

        case (state_q)
            ST_RUN: begin
                if (mode_evt) begin
                    state_d    = ST_SET_HOUR;
                    set_hour_d = cur_hour;
                    set_min_d  = cur_min;
                end
            end
            ST_SET_HOUR: begin
                if (mode_evt)
                    state_d = ST_SET_MIN;
                else if (adj_inc)
                    set_hour_d = (set_hour_q == 5'd23) ? 5'd0 : set_hour_q + 5'd1;
                else if (adj_dec)
                    set_hour_d = (set_hour_q == 5'd0) ? 5'd23 : set_hour_q - 5'd1;
            end
            ST_SET_MIN: begin
                if (mode_evt) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (adj_inc) begin
                    set_min_d = (set_min_q == 6'd59) ? 6'd0 : set_min_q + 6'd1;
                end else if (adj_dec) begin
                    set_min_d = (set_min_q == 6'd0) ? 6'd59 : set_min_q - 6'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // A press in the same cycle as expiry wins and restarts the idle timer
        if (state_q != ST_RUN && !any_evt) begin
            if (idle_q == TO_LAST)
                state_d = ST_RUN;
            else
                idle_d = idle_q + 1'b1;
        end

        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (state_d != state_q) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BL_LAST) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            set_hour_q <= 5'd0;
            set_min_q  <= 6'd0;
            load_q     <= 1'b0;
            idle_q     <= '0;
            blink_q    <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            set_hour_q <= set_hour_d;
            set_min_q  <= set_min_d;
            load_q     <= load_d;
            idle_q     <= idle_d;
            blink_q    <= blink_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign set_hour  = set_hour_q;
    assign set_min   = set_min_q;
    assign load      = load_q;
    assign blink     = blink_q;
    assign editing   = (state_q != ST_RUN);
    assign field_sel = (state_q == ST_SET_HOUR) ? 2'b01 :
                       (state_q == ST_SET_MIN)  ? 2'b10 : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Brief    : Directed self-checking bench for time_set_ctrl with short timers.
// Revision : 1.0
// ============================================================================
module tb_time_set_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode, btn_inc, btn_dec;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       load;
    logic       editing;
    logic [1:0] field_sel;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int base;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .TIMEOUT_CYCLES    (200),
        .BLINK_HALF_CYCLES (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .load      (load),
        .editing   (editing),
        .field_sel (field_sel),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (load === 1'b1) load_cnt <= load_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the buttons in mask {dec,inc,mode} long enough to debounce, then releases
    task automatic press(input logic [2:0] m);
        {btn_dec, btn_inc, btn_mode} = m;
        step(8);
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        step(8);
    endtask

    initial begin
        rst = 1'b1;
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        cur_hour = 5'd22;
        cur_min  = 6'd58;
        step(3);
        check("rst_hour",  set_hour, 0);
        check("rst_min",   set_min, 0);
        check("rst_load",  load, 0);
        check("rst_edit",  editing, 0);
        check("rst_field", field_sel, 0);
        check("rst_blink", blink, 0);
        rst = 1'b0;
        step(2);

        // Full set: 22:58 -> 00:00
        press(3'b001);
        check("fs_edit",  editing, 1);
        check("fs_field_h", field_sel, 1);
        check("fs_copy_h", set_hour, 22);
        check("fs_copy_m", set_min, 58);
        press(3'b010);
        press(3'b010);
        check("fs_hour_wrap", set_hour, 0);
        press(3'b001);
        check("fs_field_m", field_sel, 2);
        press(3'b010);
        press(3'b010);
        check("fs_min_wrap", set_min, 0);
        check("fs_hour_keep", set_hour, 0);
        base = load_cnt;
        btn_mode = 1'b1;
        step(6);
        check("fs_load_pre", load, 0);
        check("fs_edit_pre", editing, 1);
        step(1);
        check("fs_load_pulse", load, 1);
        check("fs_edit_off", editing, 0);
        check("fs_field_off", field_sel, 0);
        step(1);
        check("fs_load_drop", load, 0);
        btn_mode = 1'b0;
        step(8);
        check("fs_load_count", load_cnt - base, 1);
        check("fs_final_h", set_hour, 0);
        check("fs_final_m", set_min, 0);

        // Timeout and blink from SET_HOUR entry
        base = load_cnt;
        btn_mode = 1'b1;
        step(7);
        check("to_entry_edit", editing, 1);
        check("to_entry_blink", blink, 1);
        btn_mode = 1'b0;
        step(7);
        check("to_blink_hold", blink, 1);
        step(1);
        check("to_blink_toggle", blink, 0);
        step(191);
        check("to_still_edit", editing, 1);
        step(1);
        check("to_run", editing, 0);
        check("to_field", field_sel, 0);
        check("to_blink_off", blink, 0);
        check("to_no_load", load_cnt - base, 0);
        check("to_hold_h", set_hour, 22);
        check("to_hold_m", set_min, 58);

        // Wrap down on both fields
        cur_hour = 5'd0;
        cur_min  = 6'd0;
        press(3'b001);
        press(3'b100);
        check("wd_hour", set_hour, 23);
        press(3'b001);
        press(3'b100);
        check("wd_min", set_min, 59);

        // Simultaneous inc+dec, then mode+inc
        press(3'b110);
        check("sim_incdec", set_min, 59);
        check("sim_still_min", field_sel, 2);
        press(3'b001);
        cur_hour = 5'd10;
        cur_min  = 6'd30;
        press(3'b001);
        check("sim_enter_h", set_hour, 10);
        press(3'b011);
        check("sim_mode_field", field_sel, 2);
        check("sim_mode_hour", set_hour, 10);
        check("sim_mode_min", set_min, 30);

        // Reset mid-edit
        base = load_cnt;
        rst = 1'b1;
        step(1);
        check("rme_hour", set_hour, 0);
        check("rme_min", set_min, 0);
        check("rme_edit", editing, 0);
        check("rme_field", field_sel, 0);
        check("rme_blink", blink, 0);
        check("rme_load", load, 0);
        rst = 1'b0;
        step(2);
        check("rme_no_load", load_cnt - base, 0);

        // Bounce on inc while in SET_HOUR
        cur_hour = 5'd5;
        press(3'b001);
        check("bn_enter", set_hour, 5);
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~btn_inc;
            step(2);
        end
        check("bn_no_pulse", set_hour, 5);
        btn_inc = 1'b1;
        step(6);
        check("bn_before", set_hour, 5);
        step(1);
        check("bn_after", set_hour, 6);
        step(10);
        btn_inc = 1'b0;
        step(10);
        check("bn_single", set_hour, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
